// File: rtl/tbus_arbiter.sv
// Round-robin arbiter for N_REQ requesters sharing one internal tristate bus.
// A grant is one-hot on GNT/EN and lasts 1..MAX_HOLD cycles. Every ownership
// ends with a single dead TURNAROUND cycle so that two drivers never overlap.
// All outputs come straight from flops; CLR clears them asynchronously.
module tbus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8,
    localparam int OW      = $clog2(N_REQ)
) (
    input  logic             CP,
    input  logic             CLR,
    input  logic [N_REQ-1:0] REQ,
    output logic [N_REQ-1:0] GNT,
    output logic [N_REQ-1:0] EN,
    output logic [OW-1:0]    OWNER,
    output logic             BUSY,
    output logic             TURN
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    state_t           state_q;
    logic [N_REQ-1:0] gnt_q;
    logic [OW-1:0]    owner_q;
    logic [OW-1:0]    last_q;
    logic [7:0]       hold_q;
    logic             busy_q;
    logic             turn_q;

    logic [OW-1:0]    win_idx_d;
    logic             win_vld_d;
    logic [N_REQ-1:0] win_gnt_d;
    logic             release_d;

    // Round-robin search upward from last_q+1; the most recent owner is
    // visited last, so it only wins again when nobody else is requesting.
    // Scanning from the far end lets the nearest set bit overwrite the rest.
    always_comb begin
        win_idx_d = '0;
        win_vld_d = |REQ;
        for (int i = N_REQ; i >= 1; i--) begin
            win_idx_d = REQ[(int'(last_q) + i) % N_REQ]
                        ? OW'((int'(last_q) + i) % N_REQ)
                        : win_idx_d;
        end
        win_gnt_d = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx_d;
    end

    // The owner gives up the bus when it drops its request or hits the cap.
    always_comb begin
        release_d = 1'b0;
        if (!REQ[owner_q] || (hold_q == 8'(MAX_HOLD))) begin
            release_d = 1'b1;
        end else begin
            release_d = 1'b0;
        end
    end

    // Arbitration FSM with all outputs registered alongside the state.
    always_ff @(posedge CP or posedge CLR) begin
        if (CLR) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            last_q  <= OW'(N_REQ - 1);
            hold_q  <= 8'd0;
            busy_q  <= 1'b0;
            turn_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_TURN: begin
                    if (win_vld_d) begin
                        state_q <= ST_OWN;
                        gnt_q   <= win_gnt_d;
                        owner_q <= win_idx_d;
                        last_q  <= win_idx_d;
                        hold_q  <= 8'd1;
                        busy_q  <= 1'b1;
                        turn_q  <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                        gnt_q   <= '0;
                        owner_q <= '0;
                        hold_q  <= 8'd0;
                        busy_q  <= 1'b0;
                        turn_q  <= 1'b0;
                    end
                end
                ST_OWN: begin
                    if (release_d) begin
                        state_q <= ST_TURN;
                        gnt_q   <= '0;
                        owner_q <= '0;
                        hold_q  <= 8'd0;
                        busy_q  <= 1'b0;
                        turn_q  <= 1'b1;
                    end else begin
                        hold_q  <= hold_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    owner_q <= '0;
                    hold_q  <= 8'd0;
                    busy_q  <= 1'b0;
                    turn_q  <= 1'b0;
                end
            endcase
        end
    end

    assign GNT   = gnt_q;
    assign EN    = gnt_q;
    assign OWNER = owner_q;
    assign BUSY  = busy_q;
    assign TURN  = turn_q;

endmodule
